// File: rtl/pe_colsum_sequencer_if.sv
// PE-row partial-sum input and output-pixel stream of one PE column sequencer.
// Latency/backpressure are set by the attached sequencer; this only groups the handshake signals.
interface pe_colsum_sequencer_if #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 8
);
  logic signed [IN_W-1:0] i_pe_row;
  logic                   i_pe_valid;
  logic                   o_pe_ready;
  logic [OUT_W-1:0]       o_pix;
  logic                   o_pix_valid;
  logic                   i_pix_ready;
  logic                   o_pix_last;

  modport master (
    output i_pe_row, i_pe_valid, i_pix_ready,
    input  o_pe_ready, o_pix, o_pix_valid, o_pix_last
  );

  modport slave (
    input  i_pe_row, i_pe_valid, i_pix_ready,
    output o_pe_ready, o_pix, o_pix_valid, o_pix_last
  );
endinterface

// File: rtl/pe_colsum_sequencer.sv
// Sums three signed PE row partials per pixel, clamps to OUT_W bits, counts pixels per line.
// Pixel valid the cycle after the 3rd row beat; row input is stalled while a pixel waits for ready.
module pe_colsum_sequencer #(
  parameter int IN_W     = 11,
  parameter int OUT_W    = 8,
  parameter int LINE_PIX = 640,
  parameter int CNT_W    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  pe_colsum_sequencer_if.slave pe,
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int ACC_W = IN_W + 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ROW1 = 3'd1;
  localparam logic [2:0] S_ROW2 = 3'd2;
  localparam logic [2:0] S_ROW3 = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_PIX - 1);

  logic [2:0]              state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] row_ext;
  logic signed [ACC_W-1:0] sum;
  logic [CNT_W-1:0]        pix_cnt;
  logic [OUT_W-1:0]        pix_q;
  logic [OUT_W-1:0]        pix_sat;
  logic                    in_row;
  logic                    beat;
  logic                    last;

  assign in_row  = (state == S_ROW1) || (state == S_ROW2) || (state == S_ROW3);
  assign beat    = in_row && pe.i_pe_valid;
  assign row_ext = {{2{pe.i_pe_row[IN_W-1]}}, pe.i_pe_row};
  assign sum     = acc + row_ext;
  assign last    = (pix_cnt == LAST_IDX);

  // Negative sums clamp to zero; any magnitude bit above OUT_W clamps to full scale.
  always_comb begin
    pix_sat = sum[OUT_W-1:0];
    if (sum[ACC_W-1]) begin
      pix_sat = '0;
    end else if (|sum[ACC_W-2:OUT_W]) begin
      pix_sat = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      pix_cnt <= '0;
      pix_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state   <= S_ROW1;
            pix_cnt <= '0;
          end
        end
        S_ROW1: begin
          if (beat) begin
            acc   <= row_ext;
            state <= S_ROW2;
          end
        end
        S_ROW2: begin
          if (beat) begin
            acc   <= sum;
            state <= S_ROW3;
          end
        end
        S_ROW3: begin
          if (beat) begin
            pix_q <= pix_sat;
            state <= S_OUT;
          end
        end
        S_OUT: begin
          if (pe.i_pix_ready) begin
            if (last) begin
              state <= S_DONE;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
              state   <= S_ROW1;
            end
          end
        end
        S_DONE: begin
          pix_cnt <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pe.o_pe_ready  = in_row;
  assign pe.o_pix       = pix_q;
  assign pe.o_pix_valid = (state == S_OUT);
  assign pe.o_pix_last  = (state == S_OUT) && last;
  assign o_busy         = (state != S_IDLE);
  assign o_done         = (state == S_DONE);
endmodule
